alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 345 ++++++++++++++++++++++++++++++++++
 tb/tb_alu_seq.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with single-cycle logic/arithmetic/shift ops and
// iterative unsigned multiply (shift-add) and divide (restoring).
// Optional feature macro: ALU_SEQ_DIV_EN enables the DIVU datapath (op 17);
// without it op 17 behaves as an illegal opcode.
module alu_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] c_hi,
    output logic [7:0]       flags
);

    localparam int unsigned LW = $clog2(WIDTH);

    // Flag bit positions inside the 6-bit flag register
    localparam int unsigned FCF = 0;
    localparam int unsigned FAF = 1;
    localparam int unsigned FZF = 2;
    localparam int unsigned FSF = 3;
    localparam int unsigned FPF = 4;
    localparam int unsigned FVF = 5;

    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MAX_POS  = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [LW-1:0]    LAST_IT  = LW'(WIDTH - 1);

    typedef enum logic [4:0] {
        OP_AND    = 5'd0,
        OP_NAND   = 5'd1,
        OP_OR     = 5'd2,
        OP_NOR    = 5'd3,
        OP_XOR    = 5'd4,
        OP_XNOR   = 5'd5,
        OP_ADD    = 5'd6,
        OP_SUB    = 5'd7,
        OP_NOT    = 5'd8,
        OP_NEG    = 5'd9,
        OP_INC    = 5'd10,
        OP_DEC    = 5'd11,
        OP_SHR    = 5'd12,
        OP_SHL    = 5'd13,
        OP_SAR    = 5'd14,
        OP_MIRROR = 5'd15,
        OP_MUL    = 5'd16,
        OP_DIVU   = 5'd17,
        OP_ROL    = 5'd18,
        OP_ROR    = 5'd19,
        OP_ADC    = 5'd20,
        OP_SBB    = 5'd21
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ITER,
        S_FIN
    } state_e;

    state_e           r_state;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_c;
    logic [WIDTH-1:0] r_chi;
    logic [5:0]       r_flags;
    logic [LW-1:0]    r_cnt;
    logic             r_mul;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_bop;

    // Single-cycle datapath
    logic [WIDTH:0]   w_ax;
    logic [WIDTH:0]   w_bx;
    logic             w_cin;
    logic [WIDTH:0]   w_add;
    logic [WIDTH:0]   w_sub;
    logic             w_add_af;
    logic             w_sub_af;
    logic             w_add_vf;
    logic             w_sub_vf;
    logic [31:0]      w_cnt;
    logic             w_big;
    logic [LW-1:0]    w_sidx;
    logic [LW-1:0]    w_lidx;
    logic [31:0]      w_rn;
    logic [WIDTH-1:0] w_c;
    logic [WIDTH-1:0] w_chi;
    logic [5:0]       w_fl;
    logic             w_zsp;
    logic             w_multi;
    logic             w_is_mul;

    // Iteration datapath
    logic [WIDTH:0]   w_madd;
    logic [WIDTH-1:0] w_mhi;
    logic [WIDTH-1:0] w_mlo;
    logic [WIDTH-1:0] w_drem;
    logic [WIDTH-1:0] w_dquo;
    logic [WIDTH-1:0] w_nhi;
    logic [WIDTH-1:0] w_nlo;
    logic [5:0]       w_ffl;

    assign w_ax  = {1'b0, a};
    assign w_bx  = {1'b0, b};
    assign w_cin = ((op == OP_ADC) || (op == OP_SBB)) ? r_flags[FCF] : 1'b0;
    assign w_add = w_ax + w_bx + {{WIDTH{1'b0}}, w_cin};
    assign w_sub = w_ax - w_bx - {{WIDTH{1'b0}}, w_cin};

    // Carry/borrow into bit 4 recovered from the sum bit: a4 ^ b4 ^ s4
    assign w_add_af = w_ax[4] ^ w_bx[4] ^ w_add[4];
    assign w_sub_af = w_ax[4] ^ w_bx[4] ^ w_sub[4];
    assign w_add_vf = (a[WIDTH-1] == b[WIDTH-1]) && (w_add[WIDTH-1] != a[WIDTH-1]);
    assign w_sub_vf = (a[WIDTH-1] != b[WIDTH-1]) && (w_sub[WIDTH-1] != a[WIDTH-1]);

    assign w_cnt  = 32'(b);
    assign w_big  = (w_cnt >= WIDTH);
    assign w_sidx = LW'(w_cnt - 32'd1);
    assign w_lidx = LW'(WIDTH - w_cnt);
    assign w_rn   = w_cnt % WIDTH;

    // Decode and evaluate single-cycle ops; flag multi-cycle launches
    always_comb begin
        w_c      = '0;
        w_chi    = '0;
        w_fl     = r_flags;
        w_zsp    = 1'b1;
        w_multi  = 1'b0;
        w_is_mul = 1'b0;
        case (op)
            OP_AND:  begin w_c = a & b;    w_fl[FCF] = 1'b0; w_fl[FVF] = 1'b0; end
            OP_NAND: begin w_c = ~(a & b); w_fl[FCF] = 1'b0; w_fl[FVF] = 1'b0; end
            OP_OR:   begin w_c = a | b;    w_fl[FCF] = 1'b0; w_fl[FVF] = 1'b0; end
            OP_NOR:  begin w_c = ~(a | b); w_fl[FCF] = 1'b0; w_fl[FVF] = 1'b0; end
            OP_XOR:  begin w_c = a ^ b;    w_fl[FCF] = 1'b0; w_fl[FVF] = 1'b0; end
            OP_XNOR: begin w_c = ~(a ^ b); w_fl[FCF] = 1'b0; w_fl[FVF] = 1'b0; end
            OP_ADD, OP_ADC: begin
                w_c       = w_add[WIDTH-1:0];
                w_fl[FCF] = w_add[WIDTH];
                w_fl[FAF] = w_add_af;
                w_fl[FVF] = w_add_vf;
            end
            OP_SUB, OP_SBB: begin
                w_c       = w_sub[WIDTH-1:0];
                w_fl[FCF] = w_sub[WIDTH];
                w_fl[FAF] = w_sub_af;
                w_fl[FVF] = w_sub_vf;
            end
            OP_NOT: begin
                w_c   = ~a;
                w_zsp = 1'b0;
            end
            OP_NEG: begin
                w_c       = ~a + ONE;
                w_fl[FCF] = (a != '0);
                w_fl[FAF] = (a[3:0] != 4'h0);
                w_fl[FVF] = (a == MSB_ONLY);
            end
            OP_INC: begin
                w_c       = a + ONE;
                w_fl[FAF] = (a[3:0] == 4'hF);
                w_fl[FVF] = (a == MAX_POS);
            end
            OP_DEC: begin
                w_c       = a - ONE;
                w_fl[FAF] = (a[3:0] == 4'h0);
                w_fl[FVF] = (a == MSB_ONLY);
            end
            OP_SHR: begin
                if (w_cnt == 32'd0) begin
                    w_c = a;
                end else if (w_big) begin
                    w_c       = '0;
                    w_fl[FCF] = 1'b0;
                end else begin
                    w_c       = a >> w_cnt;
                    w_fl[FCF] = a[w_sidx];
                end
            end
            OP_SHL: begin
                if (w_cnt == 32'd0) begin
                    w_c = a;
                end else if (w_big) begin
                    w_c       = '0;
                    w_fl[FCF] = 1'b0;
                end else begin
                    w_c       = a << w_cnt;
                    w_fl[FCF] = a[w_lidx];
                end
            end
            OP_SAR: begin
                if (w_cnt == 32'd0) begin
                    w_c = a;
                end else if (w_big) begin
                    w_c       = {WIDTH{a[WIDTH-1]}};
                    w_fl[FCF] = a[WIDTH-1];
                end else begin
                    w_c       = $unsigned($signed(a) >>> w_cnt);
                    w_fl[FCF] = a[w_sidx];
                end
            end
            OP_MIRROR: begin
                for (int unsigned i = 0; i < WIDTH; i++) begin
                    w_c[i] = a[WIDTH-1-i];
                end
                w_zsp = 1'b0;
            end
            // Last bit rotated out lands in c[0] for ROL and c[MSB] for ROR
            OP_ROL: begin
                w_c = (a << w_rn) | (a >> (WIDTH - w_rn));
                if (w_cnt != 32'd0) w_fl[FCF] = w_c[0];
            end
            OP_ROR: begin
                w_c = (a >> w_rn) | (a << (WIDTH - w_rn));
                if (w_cnt != 32'd0) w_fl[FCF] = w_c[WIDTH-1];
            end
            OP_MUL: begin
                w_multi  = 1'b1;
                w_is_mul = 1'b1;
            end
`ifdef ALU_SEQ_DIV_EN
            OP_DIVU: begin
                if (b == '0) begin
                    w_c       = '1;
                    w_chi     = a;
                    w_fl[FCF] = 1'b0;
                    w_fl[FVF] = 1'b1;
                end else begin
                    w_multi = 1'b1;
                end
            end
`endif
            default: begin
                w_zsp = 1'b0;
            end
        endcase
        if (w_zsp) begin
            w_fl[FZF] = (w_c == '0);
            w_fl[FSF] = w_c[WIDTH-1];
            w_fl[FPF] = ~^w_c;
        end
    end

    // Shift-add multiply step: {r_hi, r_lo} holds partial product / multiplier
    assign w_madd = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_bop} : '0);
    assign w_mhi  = w_madd[WIDTH:1];
    assign w_mlo  = {w_madd[0], r_lo[WIDTH-1:1]};

`ifdef ALU_SEQ_DIV_EN
    logic [WIDTH:0]   w_dsh;
    logic             w_dge;
    logic [WIDTH-1:0] w_ddif;

    // Restoring divide step: r_hi is the partial remainder, r_lo shifts
    // dividend bits out and quotient bits in
    assign w_dsh  = {r_hi, r_lo[WIDTH-1]};
    assign w_dge  = (w_dsh >= {1'b0, r_bop});
    assign w_ddif = w_dsh[WIDTH-1:0] - r_bop;
    assign w_drem = w_dge ? w_ddif : w_dsh[WIDTH-1:0];
    assign w_dquo = {r_lo[WIDTH-2:0], w_dge};
`else
    assign w_drem = '0;
    assign w_dquo = '0;
`endif

    // Select next iteration state and the flags written on the final step
    always_comb begin
        w_nhi      = r_mul ? w_mhi : w_drem;
        w_nlo      = r_mul ? w_mlo : w_dquo;
        w_ffl      = r_flags;
        w_ffl[FCF] = r_mul && (w_mhi != '0);
        w_ffl[FVF] = r_mul && (w_mhi != '0);
        w_ffl[FZF] = r_mul ? ((w_nhi == '0) && (w_nlo == '0)) : (w_nlo == '0);
        w_ffl[FSF] = w_nlo[WIDTH-1];
        w_ffl[FPF] = ~^w_nlo;
    end

    // Control FSM with registered results; FIN also accepts a new launch so
    // that an op can be issued in the same cycle done is high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_c     <= '0;
            r_chi   <= '0;
            r_flags <= '0;
            r_cnt   <= '0;
            r_mul   <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_bop   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_ITER: begin
                    r_cnt <= r_cnt + LW'(1);
                    r_hi  <= w_nhi;
                    r_lo  <= w_nlo;
                    if (r_cnt == LAST_IT) begin
                        r_state <= S_FIN;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_c     <= w_nlo;
                        r_chi   <= w_nhi;
                        r_flags <= w_ffl;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    if (start) begin
                        if (w_multi) begin
                            r_state <= S_ITER;
                            r_busy  <= 1'b1;
                            r_cnt   <= '0;
                            r_mul   <= w_is_mul;
                            r_hi    <= '0;
                            r_lo    <= a;
                            r_bop   <= b;
                        end else begin
                            r_done  <= 1'b1;
                            r_c     <= w_c;
                            r_chi   <= w_chi;
                            r_flags <= w_fl;
                        end
                    end
                end
            endcase
        end
    end

    assign busy  = r_busy;
    assign done  = r_done;
    assign c     = r_c;
    assign c_hi  = r_chi;
    assign flags = {2'b00, r_flags};

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors with hand-computed results; a scoreboard queue
// holds expected responses and a monitor checks them on every done pulse.
`timescale 1ns/1ps
module tb_alu_seq;

    localparam int unsigned W = 8;

    localparam logic [4:0] OP_AND    = 5'd0;
    localparam logic [4:0] OP_XOR    = 5'd4;
    localparam logic [4:0] OP_ADD    = 5'd6;
    localparam logic [4:0] OP_SUB    = 5'd7;
    localparam logic [4:0] OP_NOT    = 5'd8;
    localparam logic [4:0] OP_NEG    = 5'd9;
    localparam logic [4:0] OP_INC    = 5'd10;
    localparam logic [4:0] OP_DEC    = 5'd11;
    localparam logic [4:0] OP_SHR    = 5'd12;
    localparam logic [4:0] OP_SHL    = 5'd13;
    localparam logic [4:0] OP_SAR    = 5'd14;
    localparam logic [4:0] OP_MIRROR = 5'd15;
    localparam logic [4:0] OP_MUL    = 5'd16;
    localparam logic [4:0] OP_DIVU   = 5'd17;
    localparam logic [4:0] OP_ROL    = 5'd18;
    localparam logic [4:0] OP_ROR    = 5'd19;
    localparam logic [4:0] OP_ADC    = 5'd20;
    localparam logic [4:0] OP_SBB    = 5'd21;
    localparam logic [4:0] OP_ILL    = 5'd25;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [4:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] c;
    logic [W-1:0] c_hi;
    logic [7:0]   flags;

    alu_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .c     (c),
        .c_hi  (c_hi),
        .flags (flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [7:0] c;
        logic [7:0] chi;
        logic [7:0] fl;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Drive one launch at the current negedge and advance one cycle
    task automatic send(input string name, input logic [4:0] o, input logic [7:0] ia,
                        input logic [7:0] ib, input logic [7:0] ec, input logic [7:0] ech,
                        input logic [7:0] ef, input bit push);
        exp_t e;
        start = 1'b1;
        op    = o;
        a     = ia;
        b     = ib;
        if (push) begin
            e.name = name;
            e.c    = ec;
            e.chi  = ech;
            e.fl   = ef;
            q.push_back(e);
        end
        @(negedge clk);
    endtask

    // Wait (bounded) for done of a multi-cycle op, counting busy cycles;
    // operands are scrambled and an optional ADD start is pulsed mid-run
    task automatic wait_done(input string name, input int exp_busy, input bit inject);
        int nb   = 0;
        bit seen = 1'b0;
        start = 1'b0;
        a     = 8'h5A;
        b     = 8'hA5;
        for (int k = 0; k < 64 && !seen; k++) begin
            if (done) begin
                seen = 1'b1;
            end else begin
                if (busy) nb++;
                if (inject && nb == 3) begin
                    start = 1'b1;
                    op    = OP_ADD;
                    a     = 8'h01;
                    b     = 8'h01;
                end else begin
                    start = 1'b0;
                end
                @(negedge clk);
            end
        end
        start = 1'b0;
        chk({name, "_done_seen"}, 32'(seen), 32'd1);
        chk({name, "_busy_cycles"}, 32'(nb), 32'(exp_busy));
    endtask

    // Scoreboard monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && done) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 32'(done), 32'd0);
                end else begin
                    e = q.pop_front();
                    chk({e.name, "_c"},    32'(c),     32'(e.c));
                    chk({e.name, "_c_hi"}, 32'(c_hi),  32'(e.chi));
                    chk({e.name, "_flags"}, 32'(flags), 32'(e.fl));
                    chk({e.name, "_busy"}, 32'(busy),  32'd0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        op    = 5'd0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy",  32'(busy),  32'd0);
        chk("rst_done",  32'(done),  32'd0);
        chk("rst_c",     32'(c),     32'd0);
        chk("rst_c_hi",  32'(c_hi),  32'd0);
        chk("rst_flags", 32'(flags), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Back-to-back single-cycle ops; flags chain from one to the next
        send("add_7f_01",  OP_ADD,    8'h7F, 8'h01, 8'h80, 8'h00, 8'h2A, 1'b1);
        send("add_ff_01",  OP_ADD,    8'hFF, 8'h01, 8'h00, 8'h00, 8'h17, 1'b1);
        send("adc_00_00",  OP_ADC,    8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 1'b1);
        send("not_00",     OP_NOT,    8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 1'b1);
        send("sub_00_01",  OP_SUB,    8'h00, 8'h01, 8'hFF, 8'h00, 8'h1B, 1'b1);
        send("mirror_01",  OP_MIRROR, 8'h01, 8'h00, 8'h80, 8'h00, 8'h1B, 1'b1);
        send("not_0f",     OP_NOT,    8'h0F, 8'h00, 8'hF0, 8'h00, 8'h1B, 1'b1);
        send("sbb_10_01",  OP_SBB,    8'h10, 8'h01, 8'h0E, 8'h00, 8'h02, 1'b1);
        send("and_f0_3c",  OP_AND,    8'hF0, 8'h3C, 8'h30, 8'h00, 8'h12, 1'b1);
        send("xor_aa_aa",  OP_XOR,    8'hAA, 8'hAA, 8'h00, 8'h00, 8'h16, 1'b1);
        send("neg_80",     OP_NEG,    8'h80, 8'h00, 8'h80, 8'h00, 8'h29, 1'b1);
        send("inc_7f",     OP_INC,    8'h7F, 8'h00, 8'h80, 8'h00, 8'h2B, 1'b1);
        send("dec_00",     OP_DEC,    8'h00, 8'h00, 8'hFF, 8'h00, 8'h1B, 1'b1);
        send("shl_81_1",   OP_SHL,    8'h81, 8'h01, 8'h02, 8'h00, 8'h03, 1'b1);
        send("sar_80_9",   OP_SAR,    8'h80, 8'h09, 8'hFF, 8'h00, 8'h1B, 1'b1);
        send("ror_01_9",   OP_ROR,    8'h01, 8'h09, 8'h80, 8'h00, 8'h0B, 1'b1);
        send("shr_81_0",   OP_SHR,    8'h81, 8'h00, 8'h81, 8'h00, 8'h1B, 1'b1);
        send("shr_81_8",   OP_SHR,    8'h81, 8'h08, 8'h00, 8'h00, 8'h16, 1'b1);
        send("rol_81_1",   OP_ROL,    8'h81, 8'h01, 8'h03, 8'h00, 8'h13, 1'b1);
        send("illegal_25", OP_ILL,    8'h05, 8'h05, 8'h00, 8'h00, 8'h13, 1'b1);

        // Multi-cycle multiply, with an ignored start while busy
        send("mul_ff_ff",  OP_MUL,    8'hFF, 8'hFF, 8'h01, 8'hFE, 8'h23, 1'b1);
        wait_done("mul_ff_ff", 8, 1'b1);
        send("mul_0c_0a",  OP_MUL,    8'h0C, 8'h0A, 8'h78, 8'h00, 8'h12, 1'b1);
        wait_done("mul_0c_0a", 8, 1'b0);

`ifdef ALU_SEQ_DIV_EN
        send("divu_200_7", OP_DIVU,   8'd200, 8'd7, 8'd28, 8'd4, 8'h02, 1'b1);
        wait_done("divu_200_7", 8, 1'b0);
        send("divu_by0",   OP_DIVU,   8'h35, 8'h00, 8'hFF, 8'h35, 8'h3A, 1'b1);
`else
        send("divu_200_7", OP_DIVU,   8'd200, 8'd7, 8'h00, 8'h00, 8'h12, 1'b1);
        send("divu_by0",   OP_DIVU,   8'h35, 8'h00, 8'h00, 8'h00, 8'h12, 1'b1);
`endif

        // Product with zero low half but nonzero high half, then an ADD
        // issued in the cycle where the multiply's done is high
        send("mul_10_10",  OP_MUL,    8'h10, 8'h10, 8'h00, 8'h01, 8'h33, 1'b1);
        wait_done("mul_10_10", 8, 1'b0);
        send("add_80_81",  OP_ADD,    8'h80, 8'h81, 8'h01, 8'h00, 8'h21, 1'b1);
        start = 1'b0;
        repeat (2) @(negedge clk);

        // Reset in the middle of an iteration aborts the op
        send("mul_abort",  OP_MUL,    8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 1'b0);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_busy_before_rst", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy",  32'(busy),  32'd0);
        chk("abort_done",  32'(done),  32'd0);
        chk("abort_c",     32'(c),     32'd0);
        chk("abort_c_hi",  32'(c_hi),  32'd0);
        chk("abort_flags", 32'(flags), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("post_rst_busy", 32'(busy), 32'd0);
        send("add_after_rst", OP_ADD, 8'h7F, 8'h01, 8'h80, 8'h00, 8'h2A, 1'b1);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
